// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit and receive stages.
//
// Contents:
//   parity_t    - parity mode encoding (none / even / odd).
//   tx_state_t  - transmitter frame state.
//   cnt_width() - register width needed to count 0..n-1.

package uart_pkg;

    // Parity mode. The numeric values match the integer PARITY parameter
    // used by the stages (0 = none, 1 = even, 2 = odd).
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    // Transmitter frame states, in the order they appear on the line.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Width of a counter that runs 0..n-1. This is never less than one bit,
    // so that a degenerate n still gives a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-time counter shared by the UART TX and RX stages.
//
// Counts 0..CLOCKS_PER_BIT-1 while enabled and wraps to 0. The count
// returns to 0 when the stage changes state or aborts.
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   enable  - count this cycle (the owning stage is not idle)
//   clear   - synchronous return to 0; has priority over enable
//   bit_end - high in the last clock of the current bit time

module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int            CW   = cnt_width(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Free-running bit-time counter. It wraps on its own at the end of each
    // bit, so a stage that stays in one state across several bits (data,
    // multiple stop bits) needs no extra clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Gated by enable so an idle stage never sees a spurious bit end.
    assign bit_end = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains a first-word-fall-through byte FIFO onto a UART TX line.
//
// Whenever the FIFO is non-empty and the transmitter is free, the head word
// is popped and sent as start bit, data LSB first, optional parity, and stop
// bit(s). Frames queued back to back leave no idle gap between them.
//
// Ports:
//   i_clk        - clock
//   i_rst_n      - asynchronous active-low reset
//   i_clear      - synchronous abort; drops the frame in flight
//   i_empty      - FIFO empty flag
//   i_data       - FIFO head word (valid while i_empty is low)
//   o_pop        - FIFO pop strobe (combinational)
//   o_txd        - serial line; idles high (registered)
//   o_busy       - high while a frame is in flight (registered)
//   o_frame_done - pulse in the last clock of the last stop bit

module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 16,
    parameter int STOP_BITS      = 1,
    parameter int PARITY         = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_pop,
    output logic                  o_txd,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    // Reject parameter sets the frame sequencing cannot handle.
    if (CLOCKS_PER_BIT < 2) begin : g_bad_clocks_per_bit
        $error("uart_tx_drain: CLOCKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_drain: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_drain: PARITY must be 0, 1 or 2");
    end

    localparam logic HAS_PARITY = (PARITY != int'(PAR_NONE));
    localparam logic ODD_PARITY = (PARITY == int'(PAR_ODD));

    // The bit index counts data bits in DATA and stop bits in STOP.
    localparam int               IDX_W     = cnt_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      bit_idx_next;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par_bit;
    logic                  par_next;
    logic                  txd_next;
    logic                  bit_end;
    logic                  last_stop;
    logic                  pop;
    logic                  frame_done;

    // The counter restarts on every state change, so each state begins with
    // a full bit time.
    uart_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_baud (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .enable (state != ST_IDLE),
        .clear  (i_clear || (state_next != state)),
        .bit_end(bit_end)
    );

    // Next-state logic. A pop may happen either from idle or in the very last
    // clock of a frame; the second case chains the next frame with no gap.
    // Abort overrides everything, including the pop.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        par_next     = par_bit;
        last_stop    = (bit_idx == LAST_STOP);
        frame_done   = (state == ST_STOP) && bit_end && last_stop && !i_clear;
        pop          = !i_empty && !i_clear &&
                       ((state == ST_IDLE) ||
                        ((state == ST_STOP) && bit_end && last_stop));

        if (i_clear) begin
            state_next   = ST_IDLE;
            bit_idx_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_START: begin
                    if (bit_end) begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx_next = '0;
                            state_next   = HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                            shift_next   = shift >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            state_next   = ST_IDLE;
                            bit_idx_next = '0;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    bit_idx_next = '0;
                end
            endcase

            if (pop) begin
                state_next   = ST_START;
                bit_idx_next = '0;
                shift_next   = i_data;
                par_next     = (^i_data) ^ ODD_PARITY;
            end
        end
    end

    // The line level is computed from the next state, so the registered
    // o_txd shows the new bit in the same clock the state enters it.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
            ST_PARITY: txd_next = par_next;
            default:   txd_next = 1'b1;
        endcase
    end

    // Frame state and registered outputs. Reset drives the line high at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            o_txd   <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            par_bit <= par_next;
            o_txd   <= txd_next;
            o_busy  <= (state_next != ST_IDLE);
        end
    end

    assign o_pop        = pop;
    assign o_frame_done = frame_done;

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: self-checking bench for uart_tx_drain.
//
// Four instances share clock, reset, clear and data; each has its own FIFO
// empty flag:
//   [0] no parity, 1 stop bit   [1] even parity   [2] odd parity
//   [3] no parity, 2 stop bits
// Expected line levels (one entry per clock) are queued when a byte is
// offered and consumed one per cycle once the frame is on the line.

module tb_uart_tx_drain;

    localparam int CPB = 4;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [DW-1:0] data;
    logic [3:0]    empty;
    logic [3:0]    pop;
    logic [3:0]    txd;
    logic [3:0]    busy;
    logic [3:0]    done;

    logic          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    uart_tx_drain #(.DATA_WIDTH(DW), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) u_plain (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_empty(empty[0]), .i_data(data),
        .o_pop(pop[0]), .o_txd(txd[0]), .o_busy(busy[0]), .o_frame_done(done[0]));

    uart_tx_drain #(.DATA_WIDTH(DW), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(1)) u_even (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_empty(empty[1]), .i_data(data),
        .o_pop(pop[1]), .o_txd(txd[1]), .o_busy(busy[1]), .o_frame_done(done[1]));

    uart_tx_drain #(.DATA_WIDTH(DW), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(2)) u_odd (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_empty(empty[2]), .i_data(data),
        .o_pop(pop[2]), .o_txd(txd[2]), .o_busy(busy[2]), .o_frame_done(done[2]));

    uart_tx_drain #(.DATA_WIDTH(DW), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY(0)) u_stop2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_empty(empty[3]), .i_data(data),
        .o_pop(pop[3]), .o_txd(txd[3]), .o_busy(busy[3]), .o_frame_done(done[3]));

    // Reference frame: start 0, data LSB first, parity, stop 1s; CPB clocks each.
    function automatic void push_frame(input logic [DW-1:0] b, input int par_mode, input int stops);
        logic p;
        p = ^b;
        if (par_mode == 2) p = ~p;
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++)
            for (int c = 0; c < CPB; c++) exp_q.push_back(b[i]);
        if (par_mode != 0)
            for (int c = 0; c < CPB; c++) exp_q.push_back(p);
        for (int c = 0; c < stops * CPB; c++) exp_q.push_back(1'b1);
    endfunction

    function automatic logic next_exp();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        empty = 4'hF;
        data  = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (txd !== 4'hF) begin n_err++; $display("[TB] FAIL reset_txd: got %b expected 1111", txd); end
        n_vec++;
        if (busy !== 4'h0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0000", busy); end
        n_vec++;
        if (done !== 4'h0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
        n_vec++;
        if (pop !== 4'h0) begin n_err++; $display("[TB] FAIL reset_pop: got %b expected 0000", pop); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (pop[0] !== 1'b0) begin n_err++; $display("[TB] FAIL idle_pop: got %b expected 0 (cycle %0d)", pop[0], k); end
            n_vec++;
            if (txd[0] !== 1'b1) begin n_err++; $display("[TB] FAIL idle_txd: got %b expected 1 (cycle %0d)", txd[0], k); end
            n_vec++;
            if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL idle_busy: got %b expected 0 (cycle %0d)", busy[0], k); end
        end
    endtask

    task automatic test_single_byte();
        logic e;
        @(negedge clk);
        data     = 8'hA5;
        empty[0] = 1'b0;
        push_frame(8'hA5, 0, 1);
        #1;
        n_vec++;
        if (pop[0] !== 1'b1) begin n_err++; $display("[TB] FAIL single_pop: got %b expected 1", pop[0]); end
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            empty[0] = 1'b1;
            #1;
            if (k <= 40) begin
                e = next_exp();
                n_vec++;
                if (txd[0] !== e) begin n_err++; $display("[TB] FAIL single_txd: got %b expected %b (cycle %0d)", txd[0], e, k); end
                n_vec++;
                if (busy[0] !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %b expected 1 (cycle %0d)", busy[0], k); end
                n_vec++;
                if (done[0] !== (k == 40)) begin n_err++; $display("[TB] FAIL single_done: got %b expected %b (cycle %0d)", done[0], (k == 40), k); end
                n_vec++;
                if (pop[0] !== 1'b0) begin n_err++; $display("[TB] FAIL single_extra_pop: got %b expected 0 (cycle %0d)", pop[0], k); end
            end else begin
                n_vec++;
                if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy[0]); end
                n_vec++;
                if (txd[0] !== 1'b1) begin n_err++; $display("[TB] FAIL single_txd_end: got %b expected 1", txd[0]); end
            end
        end
    endtask

    task automatic test_parity();
        logic       e;
        logic       par_exp;
        logic [1:0] sel;
        for (int s = 1; s <= 2; s++) begin
            sel     = 2'(s);
            par_exp = (s == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            data       = 8'h07;
            empty[sel] = 1'b0;
            push_frame(8'h07, s, 1);
            #1;
            n_vec++;
            if (pop[sel] !== 1'b1) begin n_err++; $display("[TB] FAIL parity_pop: got %b expected 1 (mode %0d)", pop[sel], s); end
            for (int k = 1; k <= 45; k++) begin
                @(negedge clk);
                empty[sel] = 1'b1;
                #1;
                if (k <= 44) begin
                    e = next_exp();
                    n_vec++;
                    if (txd[sel] !== e) begin n_err++; $display("[TB] FAIL parity_txd: got %b expected %b (mode %0d cycle %0d)", txd[sel], e, s, k); end
                    n_vec++;
                    if (done[sel] !== (k == 44)) begin n_err++; $display("[TB] FAIL parity_done: got %b expected %b (mode %0d cycle %0d)", done[sel], (k == 44), s, k); end
                    if (k == 38) begin
                        n_vec++;
                        if (txd[sel] !== par_exp) begin n_err++; $display("[TB] FAIL parity_bit: got %b expected %b (mode %0d)", txd[sel], par_exp, s); end
                    end
                end else begin
                    n_vec++;
                    if (busy[sel] !== 1'b0) begin n_err++; $display("[TB] FAIL parity_busy_end: got %b expected 0 (mode %0d)", busy[sel], s); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        push_frame(8'h55, 0, 1);
        push_frame(8'h0F, 0, 1);
        for (int k = 0; k <= 81; k++) begin
            @(negedge clk);
            if (k == 0)  begin data = 8'h55; empty[0] = 1'b0; end
            if (k == 1)  data = 8'h0F;
            if (k == 41) empty[0] = 1'b1;
            #1;
            n_vec++;
            if (pop[0] !== (k == 0 || k == 40)) begin n_err++; $display("[TB] FAIL b2b_pop: got %b expected %b (cycle %0d)", pop[0], (k == 0 || k == 40), k); end
            if (k >= 1 && k <= 80) begin
                e = next_exp();
                n_vec++;
                if (txd[0] !== e) begin n_err++; $display("[TB] FAIL b2b_txd: got %b expected %b (cycle %0d)", txd[0], e, k); end
                n_vec++;
                if (busy[0] !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_busy: got %b expected 1 (cycle %0d)", busy[0], k); end
                n_vec++;
                if (done[0] !== (k == 40 || k == 80)) begin n_err++; $display("[TB] FAIL b2b_done: got %b expected %b (cycle %0d)", done[0], (k == 40 || k == 80), k); end
            end
            if (k == 81) begin
                n_vec++;
                if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy[0]); end
            end
        end
    endtask

    task automatic test_stop_bits2();
        logic e;
        @(negedge clk);
        data     = 8'h81;
        empty[3] = 1'b0;
        push_frame(8'h81, 0, 2);
        #1;
        n_vec++;
        if (pop[3] !== 1'b1) begin n_err++; $display("[TB] FAIL stop2_pop: got %b expected 1", pop[3]); end
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            empty[3] = 1'b1;
            #1;
            if (k <= 44) begin
                e = next_exp();
                n_vec++;
                if (txd[3] !== e) begin n_err++; $display("[TB] FAIL stop2_txd: got %b expected %b (cycle %0d)", txd[3], e, k); end
                n_vec++;
                if (done[3] !== (k == 44)) begin n_err++; $display("[TB] FAIL stop2_done: got %b expected %b (cycle %0d)", done[3], (k == 44), k); end
                n_vec++;
                if (busy[3] !== 1'b1) begin n_err++; $display("[TB] FAIL stop2_busy: got %b expected 1 (cycle %0d)", busy[3], k); end
                if (k >= 37) begin
                    n_vec++;
                    if (txd[3] !== 1'b1) begin n_err++; $display("[TB] FAIL stop2_level: got %b expected 1 (cycle %0d)", txd[3], k); end
                end
            end else begin
                n_vec++;
                if (busy[3] !== 1'b0) begin n_err++; $display("[TB] FAIL stop2_busy_end: got %b expected 0", busy[3]); end
            end
        end
    endtask

    task automatic test_clear();
        logic e;
        push_frame(8'hFF, 0, 1);
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (k == 0)  begin data = 8'hFF; empty[0] = 1'b0; end
            if (k == 1)  empty[0] = 1'b1;
            if (k == 18) begin clear = 1'b1; data = 8'h3C; empty[0] = 1'b0; end
            if (k == 19) begin
                clear = 1'b0;
                exp_q.delete();
                push_frame(8'h3C, 0, 1);
            end
            if (k == 20) empty[0] = 1'b1;
            #1;
            if (k == 0) begin
                n_vec++;
                if (pop[0] !== 1'b1) begin n_err++; $display("[TB] FAIL clear_first_pop: got %b expected 1", pop[0]); end
            end else if (k <= 18) begin
                e = next_exp();
                n_vec++;
                if (txd[0] !== e) begin n_err++; $display("[TB] FAIL clear_txd: got %b expected %b (cycle %0d)", txd[0], e, k); end
                n_vec++;
                if (pop[0] !== 1'b0) begin n_err++; $display("[TB] FAIL clear_pop: got %b expected 0 (cycle %0d)", pop[0], k); end
                n_vec++;
                if (done[0] !== 1'b0) begin n_err++; $display("[TB] FAIL clear_done: got %b expected 0 (cycle %0d)", done[0], k); end
            end else if (k == 19) begin
                n_vec++;
                if (txd[0] !== 1'b1) begin n_err++; $display("[TB] FAIL clear_txd_after: got %b expected 1", txd[0]); end
                n_vec++;
                if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL clear_busy_after: got %b expected 0", busy[0]); end
                n_vec++;
                if (pop[0] !== 1'b1) begin n_err++; $display("[TB] FAIL clear_refill_pop: got %b expected 1", pop[0]); end
            end else if (k <= 59) begin
                e = next_exp();
                n_vec++;
                if (txd[0] !== e) begin n_err++; $display("[TB] FAIL clear_new_txd: got %b expected %b (cycle %0d)", txd[0], e, k); end
                n_vec++;
                if (done[0] !== (k == 59)) begin n_err++; $display("[TB] FAIL clear_new_done: got %b expected %b (cycle %0d)", done[0], (k == 59), k); end
            end else begin
                n_vec++;
                if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL clear_new_busy_end: got %b expected 0", busy[0]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        @(negedge clk);
        data     = 8'h00;
        empty[0] = 1'b0;
        push_frame(8'h00, 0, 1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            e = next_exp();
            n_vec++;
            if (txd[0] !== e) begin n_err++; $display("[TB] FAIL rstmid_txd: got %b expected %b (cycle %0d)", txd[0], e, k); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if (txd[0] !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_txd_async: got %b expected 1", txd[0]); end
        n_vec++;
        if (busy[0] !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy_async: got %b expected 0", busy[0]); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (pop[0] !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_first_pop: got %b expected 1", pop[0]); end
        @(negedge clk);
        #1;
        n_vec++;
        if (txd[0] !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_restart_txd: got %b expected 0", txd[0]); end
        n_vec++;
        if (busy[0] !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_restart_busy: got %b expected 1", busy[0]); end
        rst_n    = 1'b0;
        empty[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_byte();
        test_parity();
        test_back_to_back();
        test_stop_bits2();
        test_clear();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
